// File: rtl/binomial_filter_mc.sv
// Streaming multi-channel binomial low-pass filter: an input register followed by
// N-1 pairwise-add stages, each with per-channel history, under valid/ready flow control.
`timescale 1ns/1ps

module binomial_filter_mc #(
    parameter  int DW = 8,
    parameter  int N  = 4,
    parameter  int CH = 1,
    localparam int CW = (CH > 1) ? $clog2(CH) : 1,
    localparam int OW = DW + N - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_norm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic [CW-1:0] out_ch
);

    localparam int            NCH     = 1 << CW;
    localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);
    localparam logic [OW:0]   RND     = (OW + 1)'(1) << (N - 2);
    localparam logic [OW:0]   SAT     = {{N{1'b0}}, {DW{1'b1}}};

    // Round-half-up division by 2^(N-1), clamped to the input range.
    function automatic logic [OW-1:0] norm_round(input logic [OW-1:0] raw);
        logic [OW:0] sum;
        logic [OW:0] shr;
        sum = {1'b0, raw} + RND;
        shr = sum >> (N - 1);
        return (shr > SAT) ? SAT[OW-1:0] : shr[OW-1:0];
    endfunction

    // Index 0 is the input register; index s (1..N-1) holds y_s of the tagged sample.
    logic [OW-1:0] r_data [0:N-1];
    logic [N-1:0]  r_vld;
    logic [N-1:0]  r_norm;
    logic [CW-1:0] r_ch   [0:N-1];
    logic [OW-1:0] r_hist [1:N-1][0:NCH-1];
    logic [CW-1:0] r_ch_cnt;

    logic w_en;
    logic w_accept;

    assign w_en     = !r_vld[N-1] | out_ready;
    assign in_ready = rst_n & w_en & !clr;
    assign w_accept = in_valid & in_ready;

    // Control, tags and per-channel history: cleared by reset and by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_norm   <= '0;
            r_ch_cnt <= '0;
            for (int s = 0; s < N; s++) r_ch[s] <= '0;
            for (int s = 1; s < N; s++)
                for (int c = 0; c < NCH; c++) r_hist[s][c] <= '0;
        end else if (clr) begin
            r_vld    <= '0;
            r_ch_cnt <= '0;
            for (int s = 1; s < N; s++)
                for (int c = 0; c < NCH; c++) r_hist[s][c] <= '0;
        end else if (w_en) begin
            if (w_accept)
                r_ch_cnt <= (r_ch_cnt == CH_LAST) ? '0 : r_ch_cnt + CW'(1);
            // p0: capture the accepted sample and its tag
            r_vld[0]  <= w_accept;
            r_ch[0]   <= r_ch_cnt;
            r_norm[0] <= in_norm;
            // p1..p(N-1): tags shift; history only tracks real samples of a channel
            for (int s = 1; s < N; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_ch[s]   <= r_ch[s-1];
                r_norm[s] <= r_norm[s-1];
                if (r_vld[s-1])
                    r_hist[s][r_ch[s-1]] <= r_data[s-1];
            end
        end
    end

    // Datapath: no reset, validity is carried entirely by r_vld.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_data[0] <= OW'(in_data);
            for (int s = 1; s < N; s++)
                r_data[s] <= r_data[s-1] + r_hist[s][r_ch[s-1]];
        end
    end

    assign out_valid = r_vld[N-1];
    assign out_ch    = r_ch[N-1];
    assign out_data  = !r_vld[N-1] ? '0 :
                       r_norm[N-1] ? norm_round(r_data[N-1]) : r_data[N-1];

endmodule

// File: tb/tb_binomial_filter_mc.sv
// Directed bench for binomial_filter_mc: a single-channel instance (DW=8, N=4, CH=1)
// and a two-channel instance for the interleaving case.
`timescale 1ns/1ps

module tb_binomial_filter_mc;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int OW = DW + N - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          clr, in_valid, in_norm, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [OW-1:0] out_data;
    logic [0:0]    out_ch;

    logic          clr2, in_valid2, in_norm2, out_ready2;
    logic [DW-1:0] in_data2;
    logic          in_ready2, out_valid2;
    logic [OW-1:0] out_data2;
    logic [0:0]    out_ch2;

    binomial_filter_mc #(.DW(DW), .N(N), .CH(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_norm(in_norm),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
    );

    binomial_filter_mc #(.DW(DW), .N(N), .CH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_norm(in_norm2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_ch(out_ch2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        clr;
        logic        vld;
        logic [7:0]  din;
        logic        norm;
        logic        rdy;
        logic        ev;
        logic [10:0] ed;
    } vec_t;

    vec_t tbl [34];

    function automatic vec_t mk(input logic c, input logic v, input int d, input logic n,
                                input logic r, input logic e, input int od);
        vec_t t;
        t.clr = c; t.vld = v; t.din = 8'(d); t.norm = n;
        t.rdy = r; t.ev = e; t.ed = 11'(od);
        return t;
    endfunction

    // Drive one cycle of inputs (called at posedge+1), check in_ready mid-cycle,
    // then check the registered outputs just after the edge.
    task automatic apply(input vec_t v, input int idx);
        clr = v.clr; in_valid = v.vld; in_data = v.din; in_norm = v.norm; out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("in_ready[%0d]", idx), in_ready, v.rdy);
        @(posedge clk); #1;
        check($sformatf("out_valid[%0d]", idx), out_valid, v.ev);
        if (v.ev) begin
            check($sformatf("out_data[%0d]", idx), out_data, v.ed);
            check($sformatf("out_ch[%0d]", idx), out_ch, 0);
        end
    endtask

    int          exp_bp [21];
    int          coef [4] = '{1, 3, 3, 1};
    logic [7:0]  ch2_din [12] = '{8, 4, 0, 0, 4, 0, 0, 4, 0, 4, 0, 4};
    logic        ch2_vld [12] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    int          ch2_exp [10] = '{8, 4, 24, 16, 24, 28, 8, 32, 0, 32};

    initial begin
        tbl[0]  = mk(0, 1, 1,   0, 1, 0, 0);
        tbl[1]  = mk(0, 1, 0,   0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 0,   0, 1, 0, 0);
        tbl[3]  = mk(0, 1, 0,   0, 1, 1, 1);
        tbl[4]  = mk(0, 1, 0,   0, 1, 1, 3);
        tbl[5]  = mk(0, 0, 0,   0, 1, 1, 3);
        tbl[6]  = mk(0, 0, 0,   0, 1, 1, 1);
        tbl[7]  = mk(0, 0, 0,   0, 1, 1, 0);
        tbl[8]  = mk(1, 1, 99,  0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 255, 0, 1, 0, 0);
        tbl[10] = mk(0, 1, 255, 0, 1, 0, 0);
        tbl[11] = mk(0, 1, 255, 0, 1, 0, 0);
        tbl[12] = mk(0, 1, 255, 0, 1, 1, 255);
        tbl[13] = mk(0, 1, 255, 0, 1, 1, 1020);
        tbl[14] = mk(1, 1, 255, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 255, 1, 1, 0, 0);
        tbl[16] = mk(0, 1, 255, 1, 1, 0, 0);
        tbl[17] = mk(0, 1, 255, 1, 1, 0, 0);
        tbl[18] = mk(0, 1, 255, 1, 1, 1, 32);
        tbl[19] = mk(0, 1, 255, 1, 1, 1, 128);
        tbl[20] = mk(0, 1, 255, 0, 1, 1, 223);
        tbl[21] = mk(0, 1, 255, 0, 1, 1, 255);
        tbl[22] = mk(0, 1, 255, 0, 1, 1, 255);
        tbl[23] = mk(0, 1, 255, 0, 1, 1, 2040);
        tbl[24] = mk(0, 1, 255, 0, 1, 1, 2040);
        tbl[25] = mk(1, 1, 255, 0, 0, 0, 0);
        tbl[26] = mk(0, 1, 1,   0, 1, 0, 0);
        tbl[27] = mk(0, 1, 0,   0, 1, 0, 0);
        tbl[28] = mk(0, 1, 0,   0, 1, 0, 0);
        tbl[29] = mk(0, 1, 0,   0, 1, 1, 1);
        tbl[30] = mk(0, 0, 0,   0, 1, 1, 3);
        tbl[31] = mk(0, 0, 0,   0, 1, 1, 3);
        tbl[32] = mk(0, 0, 0,   0, 1, 1, 1);
        tbl[33] = mk(0, 0, 0,   0, 1, 0, 0);

        // Reference for the ramp: direct convolution with the [1 3 3 1] kernel.
        for (int n = 0; n < 21; n++) begin
            exp_bp[n] = 0;
            for (int k = 0; k < 4; k++)
                if (n - k >= 0) exp_bp[n] += coef[k] * (n - k);
        end

        rst_n = 1'b0;
        clr = 1'b0; in_valid = 1'b1; in_data = 8'd7; in_norm = 1'b0; out_ready = 1'b1;
        clr2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; in_norm2 = 1'b0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 34; i++) apply(tbl[i], i);

        // Ramp under random backpressure.
        begin
            int p = 0, q = 0, stall = 0;
            logic stalled, acc_in, acc_out;
            logic [OW-1:0] held, cur;
            clr = 1'b1; in_valid = 1'b0;
            @(posedge clk); #1;
            clr = 1'b0;
            for (int cyc = 0; cyc < 400 && q < 21; cyc++) begin
                in_valid = (p <= 20); in_data = 8'(p); in_norm = 1'b0;
                if (stall > 0) begin
                    out_ready = 1'b0; stall--;
                end else begin
                    out_ready = 1'b1;
                    if ($urandom_range(0, 2) == 0) stall = $urandom_range(1, 5);
                end
                @(negedge clk);
                stalled = out_valid && !out_ready;
                held    = out_data;
                cur     = out_data;
                if (stalled) check("bp_in_ready_stall", in_ready, 0);
                acc_in  = in_valid && in_ready;
                acc_out = out_valid && out_ready;
                @(posedge clk); #1;
                if (stalled) begin
                    check("bp_hold_valid", out_valid, 1);
                    check("bp_hold_data", out_data, held);
                end
                if (acc_in) p++;
                if (acc_out) begin
                    check($sformatf("bp_out[%0d]", q), cur, exp_bp[q]);
                    q++;
                end
            end
            check("bp_out_count", q, 21);
            in_valid = 1'b0; out_ready = 1'b1;
        end

        // Asynchronous reset between edges while data is in flight.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'd255; in_norm = 1'b0;
            @(posedge clk); #1;
        end
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 26; i < 34; i++) apply(tbl[i], 100 + i);

        // Two interleaved channels with input gaps.
        begin
            int q = 0;
            for (int cyc = 0; cyc < 40 && q < 10; cyc++) begin
                if (cyc < 12) begin
                    in_valid2 = ch2_vld[cyc]; in_data2 = ch2_din[cyc];
                end else begin
                    in_valid2 = 1'b0; in_data2 = '0;
                end
                out_ready2 = 1'b1;
                @(posedge clk); #1;
                if (out_valid2) begin
                    check($sformatf("ch2_data[%0d]", q), out_data2, ch2_exp[q]);
                    check($sformatf("ch2_ch[%0d]", q), out_ch2, q % 2);
                    q++;
                end
            end
            check("ch2_out_count", q, 10);
            in_valid2 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/binomial_filter_mc.md
# binomial_filter_mc

Streaming, multi-channel binomial low-pass filter. It applies the length-N kernel of binomial coefficients C(N-1,k) (a Pascal-triangle row) as a cascade of N-1 registered pairwise-add stages. It generalises the single-channel, free-running binomial filter with a valid/ready handshake, time-interleaved channels, per-sample normalisation mode and synchronous clear. It sits between a sample source and downstream DSP.

## Interface
- DW, 8, input sample width (unsigned), ≥2
- N, 4, kernel length (taps), 2..16; filter order N-1
- CH, 1, number of interleaved channels, 1..16
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of history and pipeline
- in_valid  in  1  input sample valid
- in_ready  out  1  input sample accepted when in_valid & in_ready
- in_data  in  DW  input sample
- in_norm  in  1  1 = output normalised by 2^(N-1), 0 = full precision; sampled with each input
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_data  out  DW+N-1  filtered sample (normalised results zero-extended)
- out_ch  out  clog2(CH) (min 1)  channel index of out_data

## Operation
- Channels arrive round-robin: the first accepted sample after reset or clr is ch0, then ch1 … ch CH-1, then back to ch0. The internal channel counter advances only on acceptance.
- Stage s (1..N-1) computes y_s = y_{s-1}[n] + y_{s-1}[n-1] of the same channel; y_0 = in_data. Width of stage s is DW+s. No overflow is possible.
- Each stage holds a per-channel previous-input history register (CH entries). The history is updated only when a valid sample of that channel passes the stage.
- After reset or clr, all history is zero, so the first N-1 outputs per channel include zero-padded terms.
- Tag (valid, channel, norm) travels with each sample through the pipeline.
- Output: raw = y_{N-1}. If the tag norm=1, out_data = (raw + 2^(N-2)) >> (N-1), i.e. round-half-up, with maximum 2^DW-1. Otherwise out_data = raw.
- Pipeline enable en = !out_valid | out_ready. All stages advance together when en=1, and bubbles advance too. When en=0, everything holds.
- in_ready = en & !clr.
- clr=1: on the next edge, all stage valids, all histories and the channel counter are zeroed. Input is not accepted that cycle. clr takes priority over en.
- rst_n low (asynchronous): same state as clr. out_valid=0, out_data=0, out_ch=0, in_ready=0 while in reset.

## Timing
- Latency: a sample accepted at edge k appears with out_valid=1 after edge k+N-1 (N-1 register stages). Example: N=4 gives 3 cycles.
- Throughput: one sample per cycle when out_ready is held high.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid hold stable and in_ready=0. No sample is lost or duplicated.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: the output is consumed and the input is accepted in the same edge.
- in_norm changing mid-stream affects only samples accepted after the change.
- Channel counter wraps from CH-1 to 0. With CH=1 it is constant 0.

## Test plan
- Impulse, DW=8 N=4 CH=1, norm=0: input 1,0,0,0,0 → outputs 1,3,3,1,0, first output 3 cycles after acceptance.
- Step, norm=0: constant 255 → 255,1020,1785,2040,2040…. With norm=1: 32,128,223,255,255.
- Interleave CH=2: ch0 impulse 8 followed by zeros, ch1 constant 4 → ch0 outputs 8,24,24,8,0. ch1 outputs 4,16,28,32 in alternating slots, out_ch toggling 0,1.
- Backpressure: stream a ramp 0..20 with out_ready randomly low for 1–5 cycles → output sequence identical to the out_ready=1 run. out_data is stable while stalled and in_ready=0 during the stall.
- clr mid-stream after feeding 255s, then impulse 1 → outputs 1,3,3,1 with no residual history. The clr cycle accepts nothing.
- Async reset asserted mid-stream between edges → out_valid drops immediately. After release, outputs match the fresh-start impulse response.
